alu_pattern_sequencer: RTL and testbench
========================================

// Module: alu_pattern_sequencer
// PURPOSE
//  On-chip sequencer that applies stored non-scan test patterns to the 2-bit alu.
//  Per pattern: drives ain/bin/sel, waits a settle window, strobes zout, then compares
//  it against expected bits under a per-bit mask. Accumulates fail count and the first
//  failing pattern index. Sits between the test-access loader and the alu datapath.
// PARAMETERS
//  DEPTH      16  pattern memory entries
//  AW         4   address width, clog2(DEPTH)
//  SETTLE_CYC 4   cycles between drive and strobe (>=1)
//  FAIL_W     8   fail counter width, saturating
// PORTS
//  clk              in   1     single clock, rising edge
//  rst_n            in   1     asynchronous active-low reset
//  wr_en            in   1     pattern memory write strobe
//  wr_addr          in   AW    write address
//  wr_data          in   9     {pi[4:0], xpct[1:0], mask[1:0]}; pi = {ain[1:0], bin[1:0], sel}
//  num_pat          in   AW+1  patterns to run; sampled at start; values >DEPTH clamp to DEPTH
//  start            in   1     run request; honoured only in IDLE
//  abort            in   1     stop the run and return to IDLE
//  busy             out  1     run in progress
//  done             out  1     run completed; held until next accepted start
//  pass             out  1     valid with done: fail_cnt==0
//  fail_cnt         out  FAIL_W  failing patterns, saturates at all-ones
//  first_fail_valid out  1     at least one fail in the current/last run
//  first_fail_idx   out  AW    index of the first failing pattern
//  ain, bin         out  2     registered alu operands
//  sel              out  1     registered alu select
//  zout             in   2     alu result
// BEHAVIOUR
//  Reset: state IDLE; busy, done, pass, fail_cnt, first_fail_* = 0; ain=bin=0, sel=0.
//   Memory contents are not reset.
//  Writes: when wr_en && !busy, mem[wr_addr] <= wr_data. Ignored while busy.
//  FSM: IDLE -> APPLY -> SETTLE -> MEASURE -> (APPLY | DONE); DONE -> IDLE next cycle.
//   IDLE: start=1 clears done/pass/fail_cnt/first_fail_*, sets idx=0 and latches n=clamp(num_pat).
//    If n==0, go to DONE (pass=1). Otherwise go to APPLY. busy=1 from the next cycle.
//   APPLY (1 cycle): register {ain,bin,sel} <= mem[idx].pi; load settle counter.
//   SETTLE (SETTLE_CYC cycles): outputs held stable.
//   MEASURE (1 cycle): mism = (zout ^ xpct) & mask. If mism!=0: fail_cnt++ (saturating);
//    if !first_fail_valid, set first_fail_idx=idx and first_fail_valid=1.
//    If idx==n-1, go to DONE; else idx++ and go to APPLY.
//   DONE (1 cycle): busy=0, done=1, pass=(fail_cnt==0 after last compare); go to IDLE.
//  Cost per pattern: SETTLE_CYC+2 cycles. done rises 1 cycle after the last MEASURE.
//  Bit mapping: xpct[1]/mask[1] check zout[1]; xpct[0]/mask[0] check zout[0].
//   A mask bit of 0 means don't care.
//  abort (any busy state): go to IDLE next cycle; busy=0, done=0. fail_cnt and
//   first_fail_* keep their partial values. ain/bin/sel hold their last values.
//   abort has priority over a compare in the same cycle; that compare is discarded.
//  start and abort together in IDLE: abort wins and start is ignored.
//  start while busy: ignored.
//  Asynchronous reset mid-run: immediately returns to the reset values listed above.
// TESTING
//  T1 load mem0=11101_10_11, mem1=00111_00_11, num_pat=2, start, good alu model ->
//     ain=11 bin=10 sel=1 then 00/11/1; done after 2*(SETTLE_CYC+2)+1 cycles; pass=1; fail_cnt=0.
//  T2 T1 with zout[1] stuck-at-0 -> fail_cnt=1, first_fail_idx=0, first_fail_valid=1, pass=0.
//  T3 T2 with mem0 mask=01 -> pass=1 (masked bit ignored).
//  T4 num_pat=0 -> done 2 cycles after start, pass=1; num_pat=31 -> runs DEPTH patterns.
//  T5 abort during SETTLE of pattern 1 -> busy=0 next cycle, done=0; a write issued while
//     busy leaves mem unchanged.
//  T6 rst_n low mid-MEASURE -> all outputs 0 asynchronously; new start then runs cleanly.
//     FAIL_W=2 with 5 failing patterns -> fail_cnt=3 (saturated).

Source files
------------

// File: rtl/alu_pattern_sequencer.sv
// alu_pattern_sequencer: on-chip non-scan pattern applier for the 2-bit alu.
// Each stored pattern drives ain/bin/sel, waits SETTLE_CYC cycles, strobes zout and
// compares it against the expected bits under a per-bit mask. The sequencer tracks
// a saturating fail count and the index of the first failing pattern.
module alu_pattern_sequencer #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int SETTLE_CYC = 4,
  parameter int FAIL_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [8:0]        wr_data,
  input  logic [AW:0]       num_pat,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic              first_fail_valid,
  output logic [AW-1:0]     first_fail_idx,
  output logic [1:0]        ain,
  output logic [1:0]        bin,
  output logic              sel,
  input  logic [1:0]        zout
);

  localparam int            CW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [AW:0]   DEPTH_N     = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [8:0]          r_mem [DEPTH];
  logic [AW-1:0]       r_idx;
  logic [AW:0]         r_n;
  logic [CW-1:0]       r_settle;
  logic                r_done;
  logic                r_pass;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic                r_ff_valid;
  logic [AW-1:0]       r_ff_idx;
  logic [1:0]          r_ain;
  logic [1:0]          r_bin;
  logic                r_sel;

  logic [8:0]          w_entry;
  logic [AW:0]         w_clamp;
  logic [1:0]          w_mism;
  logic                w_busy;
  logic                w_accept;
  logic                w_abort;
  logic                w_cmp;
  logic                w_last;

  // Entry layout: {ain[1:0], bin[1:0], sel, xpct[1:0], mask[1:0]}.
  // The memory is frozen while busy, so the same entry is valid in APPLY and MEASURE.
  assign w_entry  = r_mem[r_idx];
  assign w_clamp  = (num_pat > DEPTH_N) ? DEPTH_N : num_pat;
  assign w_mism   = (zout ^ w_entry[3:2]) & w_entry[1:0];
  assign w_busy   = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_MEASURE);
  // abort beats start in IDLE, and beats a compare in MEASURE.
  assign w_accept = (r_state == S_IDLE) && start && !abort;
  assign w_abort  = w_busy && abort;
  assign w_cmp    = (r_state == S_MEASURE) && !abort;
  assign w_last   = ({1'b0, r_idx} == (r_n - 1'b1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; abort from any busy state returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = (w_clamp == '0) ? S_DONE : S_APPLY;
      S_APPLY:   w_next = S_SETTLE;
      S_SETTLE:  if (r_settle == '0) w_next = S_MEASURE;
      S_MEASURE: w_next = w_last ? S_DONE : S_APPLY;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Pattern memory; loader writes are dropped while a run is in progress.
  always_ff @(posedge clk) begin
    if (wr_en && !w_busy) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Run control: pattern index, latched pattern count and settle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_n      <= '0;
      r_settle <= '0;
    end else if (w_accept) begin
      r_idx    <= '0;
      r_n      <= w_clamp;
    end else if (!w_abort) begin
      if (r_state == S_APPLY) begin
        r_settle <= SETTLE_LOAD;
      end else if (r_state == S_SETTLE && r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end else if (r_state == S_MEASURE && !w_last) begin
        r_idx    <= r_idx + 1'b1;
      end
    end
  end

  // Operand registers driving the alu; they hold across SETTLE, MEASURE and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ain <= '0;
      r_bin <= '0;
      r_sel <= 1'b0;
    end else if (r_state == S_APPLY && !abort) begin
      r_ain <= w_entry[8:7];
      r_bin <= w_entry[6:5];
      r_sel <= w_entry[4];
    end
  end

  // Result accumulation: cleared on an accepted start, updated per compare, published in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_cnt <= '0;
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if (w_accept) begin
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_cnt <= '0;
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if (w_cmp && w_mism != '0) begin
      if (r_fail_cnt != '1) begin
        r_fail_cnt <= r_fail_cnt + 1'b1;
      end
      if (!r_ff_valid) begin
        r_ff_valid <= 1'b1;
        r_ff_idx   <= r_idx;
      end
    end else if (r_state == S_DONE) begin
      r_done     <= 1'b1;
      r_pass     <= (r_fail_cnt == '0);
    end
  end

  assign busy             = w_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign fail_cnt         = r_fail_cnt;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;
  assign ain              = r_ain;
  assign bin              = r_bin;
  assign sel              = r_sel;

endmodule

// File: tb/tb_alu_pattern_sequencer.sv
// tb_alu_pattern_sequencer: randomized and directed runs of the pattern sequencer
// against a behavioural pattern-list model, with a second instance at FAIL_W=2.
module tb_alu_pattern_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int S     = 4;
  localparam int FW    = 8;
  localparam int PER   = S + 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [8:0]    wr_data = '0;
  logic [AW:0]   num_pat = '0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;

  logic          busy, done, pass, ffv, sel;
  logic [FW-1:0] fcnt;
  logic [AW-1:0] ffi;
  logic [1:0]    ain, bin, zout;

  logic          busy2, done2, pass2, ffv2, sel2;
  logic [1:0]    fcnt2;
  logic [AW-1:0] ffi2;
  logic [1:0]    ain2, bin2, zout2;

  bit            fault = 1'b0;
  logic [8:0]    tmem [DEPTH];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  alu_pattern_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE_CYC(S), .FAIL_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_pat(num_pat), .start(start), .abort(abort), .busy(busy), .done(done),
    .pass(pass), .fail_cnt(fcnt), .first_fail_valid(ffv), .first_fail_idx(ffi),
    .ain(ain), .bin(bin), .sel(sel), .zout(zout)
  );

  alu_pattern_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE_CYC(S), .FAIL_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_pat(num_pat), .start(start), .abort(abort), .busy(busy2), .done(done2),
    .pass(pass2), .fail_cnt(fcnt2), .first_fail_valid(ffv2), .first_fail_idx(ffi2),
    .ain(ain2), .bin(bin2), .sel(sel2), .zout(zout2)
  );

  // Behavioural alu: sel=1 AND, sel=0 OR; the fault forces zout[1] to 0.
  function automatic logic [1:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                         input logic s, input bit f);
    logic [1:0] z;
    z = s ? (a & b) : (a | b);
    if (f) z[1] = 1'b0;
    return z;
  endfunction

  assign zout  = alu_ref(ain, bin, sel, fault);
  assign zout2 = alu_ref(ain2, bin2, sel2, fault);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outcome of the first m patterns of the stored list.
  function automatic void model(input int m, output int cnt, output bit ff_v, output int ff_i);
    logic [8:0] e;
    logic [1:0] z;
    cnt  = 0;
    ff_v = 1'b0;
    ff_i = 0;
    for (int p = 0; p < m; p++) begin
      e = tmem[p];
      z = alu_ref(e[8:7], e[6:5], e[4], fault);
      if (((z ^ e[3:2]) & e[1:0]) != 2'b00) begin
        if (!ff_v) begin
          ff_v = 1'b1;
          ff_i = p;
        end
        cnt++;
      end
    end
  endfunction

  task automatic mem_wr(input int a, input logic [8:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    tmem[a] = d;
  endtask

  task automatic rand_fill(input int first);
    logic [4:0] pi;
    logic [1:0] good, x, mk;
    for (int a = first; a < DEPTH; a++) begin
      pi   = 5'($urandom);
      good = alu_ref(pi[4:3], pi[2:1], pi[0], 1'b0);
      x    = ($urandom_range(0, 3) == 0) ? (good ^ 2'($urandom)) : good;
      mk   = 2'($urandom);
      mem_wr(a, {pi, x, mk});
    end
  endtask

  // One run. k counts clock edges after the edge that accepts start.
  // abort_k / rst_k >= 0 inject abort or reset at the falling edge after edge k.
  task automatic run(input int nreq, input int abort_k, input int rst_k);
    int n, lim, m, ecnt, effi;
    bit effv;
    logic [8:0] e;
    n   = (nreq > DEPTH) ? DEPTH : nreq;
    lim = n * PER + 1;
    @(negedge clk);
    num_pat = (AW+1)'(nreq);
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= lim; k++) begin
      if (k > 0) @(negedge clk);
      start = (k == 3);
      chk("busy", 32'(busy), (k < n * PER) ? 32'd1 : 32'd0);
      chk("done", 32'(done), (k == lim) ? 32'd1 : 32'd0);
      if ((k % PER) == S + 1 && (k / PER) < n) begin
        e = tmem[k / PER];
        chk("operands", 32'({ain, bin, sel}), 32'(e[8:4]));
      end
      if (k == abort_k) begin
        abort   = 1'b1;
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = ~tmem[0];
        @(negedge clk);
        abort = 1'b0;
        wr_en = 1'b0;
        m = k / PER;
        if (m > n) m = n;
        model(m, ecnt, effv, effi);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_fcnt", 32'(fcnt), 32'(ecnt));
        chk("abort_ffv", 32'(ffv), 32'(effv));
        return;
      end
      if (k == rst_k) begin
        start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({busy, done, pass, ffv, ffi, fcnt, ain, bin, sel}), 32'd0);
        chk("rst_async2", 32'({busy2, done2, pass2, ffv2, ffi2, fcnt2}), 32'd0);
        #1 rst_n = 1'b1;
        return;
      end
    end
    model(n, ecnt, effv, effi);
    chk("fail_cnt", 32'(fcnt), 32'(ecnt));
    chk("ff_valid", 32'(ffv), 32'(effv));
    chk("ff_idx", 32'(ffi), 32'(effi));
    chk("pass", 32'(pass), (ecnt == 0) ? 32'd1 : 32'd0);
    chk("fail_cnt_sat", 32'(fcnt2), (ecnt > 3) ? 32'd3 : 32'(ecnt));
    chk("pass2", 32'(pass2), (ecnt == 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
  endtask

  initial begin
    logic [4:0] pi;
    logic [1:0] good;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({busy, done, pass, ffv, ffi, fcnt, ain, bin, sel}), 32'd0);
    rst_n = 1'b1;

    // Two-pattern list with a good alu, then zout[1] stuck-at-0, then bit 1 masked.
    mem_wr(0, 9'b11101_10_11);
    mem_wr(1, 9'b00111_00_11);
    fault = 1'b0;
    run(2, -1, -1);
    fault = 1'b1;
    run(2, -1, -1);
    mem_wr(0, 9'b11101_10_01);
    run(2, -1, -1);
    mem_wr(0, 9'b11101_10_11);

    // Empty run, then an oversized count clamped to DEPTH.
    run(0, -1, -1);
    rand_fill(2);
    fault = 1'b0;
    run(31, -1, -1);

    // Abort during SETTLE of pattern 1 with a write attempt; mem[0] must survive.
    fault = 1'b1;
    run(3, PER + 1, -1);
    run(1, -1, -1);

    // Reset while pattern 1 is in MEASURE, then a clean run.
    run(2, -1, PER + S + 1);
    run(2, -1, -1);

    // Five failing patterns: 8-bit counter reads 5, 2-bit counter saturates at 3.
    fault = 1'b0;
    for (int a = 0; a < 5; a++) begin
      pi   = 5'($urandom);
      good = alu_ref(pi[4:3], pi[2:1], pi[0], 1'b0);
      mem_wr(a, {pi, ~good, 2'b11});
    end
    run(5, -1, -1);

    // Randomized lists, counts and alu fault.
    for (int r = 0; r < 8; r++) begin
      rand_fill(0);
      fault = 1'($urandom);
      run($urandom_range(0, 20), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
